axi4_burst_scheduler: RTL
=========================

Name: axi4_burst_scheduler

Overview:
Burst-level controller that sits between the write/read FIFOs and the AXI4 burst engines feeding the MIG DDR3 slave, all in the ui_clk domain. It monitors FIFO fill levels and decides when a full write burst or a full read burst is issued. It serialises the two directions with round-robin fairness and generates the wrapping DDR byte addresses for each burst. Only one burst is outstanding at a time.

Parameters:
AXI_DATA_WIDTH, 128, AXI data bus width in bits
AXI_ADDR_WIDTH, 30, AXI byte-address width
AXI_BURST_LEN, 31, AXI len field; beats per burst = AXI_BURST_LEN+1
CNT_WIDTH, 8, width of FIFO level inputs, counted in AXI-width words
WR_BYTE_ADDR_BEGIN, 0, first write byte address
WR_BYTE_ADDR_END, 2047, last write byte address (inclusive)
RD_BYTE_ADDR_BEGIN, 0, first read byte address
RD_BYTE_ADDR_END, 2047, last read byte address (inclusive)

Ports:
clk  in  1  ui_clk; all logic on rising edge
aresetn  in  1  synchronous, active-low reset
wr_addr_clr  in  1  pulse; return write pointer to WR_BYTE_ADDR_BEGIN
rd_addr_clr  in  1  pulse; return read pointer to RD_BYTE_ADDR_BEGIN
rd_en  in  1  level; read bursts permitted
wrfifo_rd_cnt  in  CNT_WIDTH  words available in write FIFO
rdfifo_free_cnt  in  CNT_WIDTH  free word slots in read FIFO
wr_burst_req  out  1  request write burst
wr_burst_addr  out  AXI_ADDR_WIDTH  start byte address of write burst
wr_burst_ack  in  1  write engine accepted request
wr_burst_done  in  1  pulse; write response (B) received
rd_burst_req  out  1  request read burst
rd_burst_addr  out  AXI_ADDR_WIDTH  start byte address of read burst
rd_burst_ack  in  1  read engine accepted request
rd_burst_done  in  1  pulse; last R beat received
busy  out  1  a burst is requested or in flight
wr_burst_num  out  16  completed write bursts since reset (wraps)
rd_burst_num  out  16  completed read bursts since reset (wraps)

Behaviour:
- The clock port is clk. The reset port is aresetn: synchronous and active-low.
- BEATS = AXI_BURST_LEN+1. BURST_BYTES = BEATS*AXI_DATA_WIDTH/8 (512 at defaults).
- Reset values: both req outputs 0, busy 0, wr_burst_addr = WR_BYTE_ADDR_BEGIN, rd_burst_addr = RD_BYTE_ADDR_BEGIN, both burst counters 0, last_grant = READ (so write wins the first tie), state IDLE, both pending-clear flags 0.
- Eligibility, evaluated in IDLE:
  - wr_elig = wrfifo_rd_cnt >= BEATS.
  - rd_elig = rd_en && rdfifo_free_cnt >= BEATS.
- State machine IDLE -> WR_REQ/RD_REQ -> WR_WAIT/RD_WAIT -> IDLE:
  - IDLE, only one eligible: go to that direction's REQ state.
  - IDLE, both eligible: grant the direction opposite to last_grant, then update last_grant.
  - IDLE, neither eligible: stay in IDLE.
- Request timing: req rises the cycle after the eligible sample.
- Request hold: req stays high until ack is sampled high, then falls the next cycle. An ack in the first req cycle is legal. An ack while req is low is ignored.
- WAIT states: hold until the matching done pulse, then return to IDLE. IDLE lasts at least one cycle between bursts. A done pulse in any other state is ignored.
- busy = 1 in every state except IDLE.
- Address is stable from req rise until done.
- Address advance, on done: next = addr + BURST_BYTES. If addr + 2*BURST_BYTES - 1 > END, next = BEGIN instead. Per direction, with its own BEGIN/END.
- Burst counter increments by 1 on each done, wrapping 0xFFFF -> 0.
- Clear pulse in IDLE (or the matching direction not in flight): pointer = BEGIN on the next cycle.
- Clear pulse while that direction is in REQ/WAIT: set the pending flag; the current burst keeps its address. On done, pointer = BEGIN instead of advancing, and the flag clears.
- Clear and done in the same cycle: the clear wins, so pointer = BEGIN.
- aresetn low in any state: everything returns to reset values next edge. Any in-flight burst is abandoned and no done is awaited.

Test Plan:
- Reset, then wrfifo_rd_cnt=32, rd_en=0 -> wr_burst_req rises one cycle later with wr_burst_addr=0. Ack and done -> wr_burst_addr=512, wr_burst_num=1, busy returns to 0.
- Write-only bursts with counts held at 32 -> addresses 0, 512, 1024, 1536, then 0 (wrap). wr_burst_num=5.
- Both eligible (wrfifo_rd_cnt=40, rd_en=1, rdfifo_free_cnt=64) -> grant order W, R, W, R. rd_burst_addr sequence 0, 512.
- wrfifo_rd_cnt=31 -> no wr_burst_req. rd_en=1 with rdfifo_free_cnt=31 -> no rd_burst_req. busy stays 0.
- Ack delayed 5 cycles -> req held 5 cycles and address stable. rd_addr_clr pulsed during RD_WAIT at addr 1024 -> after done, rd_burst_addr=0, not 1536.
- aresetn low during WR_WAIT -> next cycle req=0, busy=0, addresses=BEGIN, counters=0. A subsequent stray wr_burst_done is ignored.

Source files
------------

// File: rtl/axi4_burst_scheduler.sv
// Burst scheduler between the write/read FIFOs and the AXI4 burst engines.
// It issues one full burst at a time, alternates directions on ties and keeps a wrapping DDR address per direction.
module axi4_burst_scheduler #(
   parameter int AXI_DATA_WIDTH     = 128,
   parameter int AXI_ADDR_WIDTH     = 30,
   parameter int AXI_BURST_LEN      = 31,
   parameter int CNT_WIDTH          = 8,
   parameter int WR_BYTE_ADDR_BEGIN = 0,
   parameter int WR_BYTE_ADDR_END   = 2047,
   parameter int RD_BYTE_ADDR_BEGIN = 0,
   parameter int RD_BYTE_ADDR_END   = 2047
) (
   input  logic                      clk,
   input  logic                      aresetn,
   input  logic                      wr_addr_clr,
   input  logic                      rd_addr_clr,
   input  logic                      rd_en,
   input  logic [CNT_WIDTH-1:0]      wrfifo_rd_cnt,
   input  logic [CNT_WIDTH-1:0]      rdfifo_free_cnt,
   output logic                      wr_burst_req,
   output logic [AXI_ADDR_WIDTH-1:0] wr_burst_addr,
   input  logic                      wr_burst_ack,
   input  logic                      wr_burst_done,
   output logic                      rd_burst_req,
   output logic [AXI_ADDR_WIDTH-1:0] rd_burst_addr,
   input  logic                      rd_burst_ack,
   input  logic                      rd_burst_done,
   output logic                      busy,
   output logic [15:0]               wr_burst_num,
   output logic [15:0]               rd_burst_num
);

   localparam int AW          = AXI_ADDR_WIDTH;
   localparam int BEATS       = AXI_BURST_LEN + 1;
   localparam int BURST_BYTES = BEATS * AXI_DATA_WIDTH / 8;

   localparam logic [CNT_WIDTH-1:0] BEATS_CNT = CNT_WIDTH'(BEATS);
   localparam logic [AW-1:0]        BB        = AW'(BURST_BYTES);
   localparam logic [AW:0]          BB2M1_X   = (AW+1)'(2 * BURST_BYTES - 1);
   localparam logic [AW-1:0]        WR_BEGIN  = AW'(WR_BYTE_ADDR_BEGIN);
   localparam logic [AW-1:0]        RD_BEGIN  = AW'(RD_BYTE_ADDR_BEGIN);
   localparam logic [AW:0]          WR_END_X  = (AW+1)'(WR_BYTE_ADDR_END);
   localparam logic [AW:0]          RD_END_X  = (AW+1)'(RD_BYTE_ADDR_END);

   localparam logic GRANT_WR = 1'b0;
   localparam logic GRANT_RD = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_REQ  = 3'd1,
      S_WR_WAIT = 3'd2,
      S_RD_REQ  = 3'd3,
      S_RD_WAIT = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic           last_grant_q, last_grant_d;
   logic [AW-1:0]  wr_addr_q, wr_addr_d;
   logic [AW-1:0]  rd_addr_q, rd_addr_d;
   logic           wr_pend_q, wr_pend_d;
   logic           rd_pend_q, rd_pend_d;
   logic [15:0]    wr_num_q, wr_num_d;
   logic [15:0]    rd_num_q, rd_num_d;

   logic wr_elig, rd_elig, wr_inflight, rd_inflight;

   // Next burst start; jump back to begin when the following burst would cross the end address.
   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                                input logic [AW:0]   end_x,
                                                input logic [AW-1:0] begin_a);
      logic [AW:0] last_x;
      last_x = {1'b0, a} + BB2M1_X;
      if (last_x > end_x) return begin_a;
      return a + BB;
   endfunction

   assign wr_elig     = (wrfifo_rd_cnt >= BEATS_CNT);
   assign rd_elig     = rd_en && (rdfifo_free_cnt >= BEATS_CNT);
   assign wr_inflight = (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
   assign rd_inflight = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);

   // Handshake: req is held high in the REQ state until ack is sampled high at a rising edge;
   // done is only honoured in the matching WAIT state, everything else ignores ack/done.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wr_addr_d    = wr_addr_q;
      rd_addr_d    = rd_addr_q;
      wr_pend_d    = wr_pend_q;
      rd_pend_d    = rd_pend_q;
      wr_num_d     = wr_num_q;
      rd_num_d     = rd_num_q;

      if (wr_addr_clr) begin
         if (wr_inflight) wr_pend_d = 1'b1;
         else             wr_addr_d = WR_BEGIN;
      end
      if (rd_addr_clr) begin
         if (rd_inflight) rd_pend_d = 1'b1;
         else             rd_addr_d = RD_BEGIN;
      end

      case (state_q)
         S_IDLE: begin
            if (wr_elig && (!rd_elig || last_grant_q == GRANT_RD)) begin
               state_d      = S_WR_REQ;
               last_grant_d = GRANT_WR;
            end else if (rd_elig) begin
               state_d      = S_RD_REQ;
               last_grant_d = GRANT_RD;
            end
         end
         S_WR_REQ: if (wr_burst_ack) state_d = S_WR_WAIT;
         S_RD_REQ: if (rd_burst_ack) state_d = S_RD_WAIT;
         S_WR_WAIT: begin
            if (wr_burst_done) begin
               state_d   = S_IDLE;
               wr_num_d  = wr_num_q + 16'd1;
               wr_pend_d = 1'b0;
               wr_addr_d = (wr_addr_clr || wr_pend_q) ? WR_BEGIN
                                                      : next_addr(wr_addr_q, WR_END_X, WR_BEGIN);
            end
         end
         S_RD_WAIT: begin
            if (rd_burst_done) begin
               state_d   = S_IDLE;
               rd_num_d  = rd_num_q + 16'd1;
               rd_pend_d = 1'b0;
               rd_addr_d = (rd_addr_clr || rd_pend_q) ? RD_BEGIN
                                                      : next_addr(rd_addr_q, RD_END_X, RD_BEGIN);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q      <= S_IDLE;
         last_grant_q <= GRANT_RD;
         wr_addr_q    <= WR_BEGIN;
         rd_addr_q    <= RD_BEGIN;
         wr_pend_q    <= 1'b0;
         rd_pend_q    <= 1'b0;
         wr_num_q     <= 16'd0;
         rd_num_q     <= 16'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wr_addr_q    <= wr_addr_d;
         rd_addr_q    <= rd_addr_d;
         wr_pend_q    <= wr_pend_d;
         rd_pend_q    <= rd_pend_d;
         wr_num_q     <= wr_num_d;
         rd_num_q     <= rd_num_d;
      end
   end

   assign wr_burst_req  = (state_q == S_WR_REQ);
   assign rd_burst_req  = (state_q == S_RD_REQ);
   assign busy          = (state_q != S_IDLE);
   assign wr_burst_addr = wr_addr_q;
   assign rd_burst_addr = rd_addr_q;
   assign wr_burst_num  = wr_num_q;
   assign rd_burst_num  = rd_num_q;

endmodule
